bank_cmd_arbiter: RTL and testbench
===================================

Name: bank_cmd_arbiter

Overview:
- Shares the single DRAM command bus between NUM_BANKS per-bank FSMs.
- Each cycle it picks one issuing bank and drives that bank's command onto the bus, registered.
- Losing banks receive stall so their FSMs hold state.
- Enforces per-bank tRCD/tRP and bus-wide tRRD/tCCD spacing; refresh takes priority.

Parameters:
- NUM_BANKS, 4, number of bank FSMs (power of 2, 2..8).
- ADDR_BITS, 16, row/column address width.
- T_RCD, 3, min cycles ACT→RD/WR, same bank (≥1).
- T_RP, 3, min cycles PRE→ACT/REF, same bank (≥1).
- T_RRD, 2, min cycles ACT→ACT, any banks (≥1).
- T_CCD, 2, min cycles RD/WR→RD/WR, any banks (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- bank_issue  in  NUM_BANKS  bank i presents a command this cycle.
- bank_cmd  in  3*NUM_BANKS  per-bank code: 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6/7 illegal.
- bank_addr  in  ADDR_BITS*NUM_BANKS  per-bank row/col address.
- bank_stall  out  NUM_BANKS  combinational; 1 = bank must hold state this cycle.
- cmd_valid  out  1  registered; bus command valid.
- cmd_type  out  3  registered; command code.
- cmd_bank  out  log2(NUM_BANKS)  registered; bank index.
- cmd_addr  out  ADDR_BITS  registered; address.

Behaviour:
- Reset (rst=1 at posedge):
  - cmd_valid=0, cmd_type=0, cmd_bank=0, cmd_addr=0.
  - All timing counters=0; rr_ptr=0.
  - While rst=1 no grant is made, so bank_stall = req.
- req[i] = bank_issue[i] && bank_cmd[i] ∈ {1..5}. NOP and illegal codes never request and are never stalled.
- Eligibility elig[i] = req[i] and all of:
  - ACT: rp_cnt[i]==0 and rrd_cnt==0.
  - REF: rp_cnt[i]==0.
  - RD/WR: rcd_cnt[i]==0 and ccd_cnt==0.
  - PRE: always.
- Selection, at most one grant per cycle:
  - If any eligible REF exists, grant the lowest-index eligible REF.
  - Otherwise grant the first eligible bank in round-robin order rr_ptr, rr_ptr+1, … mod NUM_BANKS.
- Outputs:
  - bank_stall[i] = req[i] && !grant[i], combinational the same cycle.
  - Non-requesting banks get bank_stall=0.
- Bus register: on the posedge after grant to bank g, cmd_valid=1 and cmd_type/cmd_bank/cmd_addr = bank g's values (latency 1). With no grant, cmd_valid=0 and the other bus fields hold.
- rr_ptr: after any grant to g, rr_ptr ← (g+1) mod NUM_BANKS. Otherwise it holds.
- Counters (saturating decrement by 1 per cycle when nonzero; width clog2(T+1)):
  - Grant ACT to g: rcd_cnt[g] ← T_RCD-1, rrd_cnt ← T_RRD-1.
  - Grant PRE to g: rp_cnt[g] ← T_RP-1.
  - Grant RD/WR: ccd_cnt ← T_CCD-1.
  - Load overrides decrement in the same cycle.
  - Net effect: a command granted at cycle c unblocks the dependent command at cycle c+T.
- T=1 means no spacing: the counter loads 0.
- Simultaneous requests: exactly one grant; all others stall. No request is dropped; a bank re-presents while stalled.
- Reset mid-operation: an in-flight bus command is discarded (cmd_valid=0 next cycle) and all counters clear, so there is no residual spacing after reset.
- No FSM beyond the rr_ptr and counters. The block is purely a cycle-by-cycle arbiter and is stateless w.r.t. bank protocol. Bank FSMs own command ordering.

Test Plan:
- Timing parameters for all scenarios: NUM_BANKS=4, T_RCD=3, T_RP=3, T_RRD=2, T_CCD=2.
- Bank0 ACT at cycle 10, then RD held → ACT on bus cycle 11; bank_stall[0]=1 cycles 11–12; RD granted cycle 13, on bus cycle 14.
- All four banks ACT at cycle 0, rr_ptr=0 → grants bank0@0, bank1@2, bank2@4, bank3@6. Stalled banks see bank_stall=1 on every non-grant cycle.
- Banks1 and 3 issue RD continuously, rr_ptr=0 → grants alternate 1,3,1,3 every 2 cycles (tCCD). cmd_bank pattern matches.
- Bank0 RD and bank2 REF at the same cycle, rr_ptr=0 → bank2 REF granted, bank_stall[0]=1; RD granted next cycle; rr_ptr=3 after the REF grant.
- Bank1 PRE at cycle 5, then ACT → ACT blocked cycles 6–7, granted cycle 8. Bank1 illegal code 7 with bank_issue=1 → no grant, bank_stall[1]=0.
- rst=1 for one cycle while rcd_cnt[0]=2 and cmd_valid=1 → next cycle cmd_valid=0, rr_ptr=0. Bank0 RD is then granted immediately on the first cycle after reset.

Source files
------------

// File: rtl/bank_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// bank_cmd_arbiter
//
// Purpose:
//   Shares one DRAM command bus between NUM_BANKS independent bank FSMs.
//   Every cycle at most one requesting bank is granted. Its command is
//   registered onto the bus one cycle later. Every other requesting bank is
//   told to stall so that its FSM holds state and re-presents the same
//   command next cycle.
//   Refresh commands win over everything else. All remaining requests are
//   served in round-robin order.
//   The arbiter enforces these command spacings:
//     - per bank: tRCD (ACT -> RD/WR) and tRP (PRE -> ACT/REF)
//     - bus wide: tRRD (ACT -> ACT) and tCCD (RD/WR -> RD/WR)
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active-high
//   bank_issue  [NUM_BANKS]            bank i presents a command this cycle
//   bank_cmd    [3*NUM_BANKS]          per-bank command code, 3 bits each
//                                      0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE,
//                                      5 REF, 6/7 illegal
//   bank_addr   [ADDR_BITS*NUM_BANKS]  per-bank row/column address
//   bank_stall  [NUM_BANKS]            combinational; bank must hold state
//   cmd_valid                          registered; bus command valid
//   cmd_type    [3]                    registered; bus command code
//   cmd_bank    [log2(NUM_BANKS)]      registered; issuing bank index
//   cmd_addr    [ADDR_BITS]            registered; bus address
// ---------------------------------------------------------------------------
module bank_cmd_arbiter #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_BITS = 16,
  parameter int T_RCD     = 3,
  parameter int T_RP      = 3,
  parameter int T_RRD     = 2,
  parameter int T_CCD     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_BANKS-1:0]           bank_issue,
  input  logic [3*NUM_BANKS-1:0]         bank_cmd,
  input  logic [ADDR_BITS*NUM_BANKS-1:0] bank_addr,
  output logic [NUM_BANKS-1:0]           bank_stall,
  output logic                           cmd_valid,
  output logic [2:0]                     cmd_type,
  output logic [$clog2(NUM_BANKS)-1:0]   cmd_bank,
  output logic [ADDR_BITS-1:0]           cmd_addr
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);

  // Each counter only needs enough bits to hold T-1. Sizing it for T keeps
  // the width at least 1 bit even when T == 1.
  localparam int RCD_W = $clog2(T_RCD + 1);
  localparam int RP_W  = $clog2(T_RP + 1);
  localparam int RRD_W = $clog2(T_RRD + 1);
  localparam int CCD_W = $clog2(T_CCD + 1);

  // A command granted at cycle c must unblock its dependent command at cycle
  // c+T. The counter is loaded at the end of cycle c and reads zero again T
  // cycles later, so the load value is T-1. When T == 1 the load value is 0,
  // which means no spacing at all.
  localparam logic [RCD_W-1:0] RCD_LOAD = RCD_W'(T_RCD - 1);
  localparam logic [RP_W-1:0]  RP_LOAD  = RP_W'(T_RP - 1);
  localparam logic [RRD_W-1:0] RRD_LOAD = RRD_W'(T_RRD - 1);
  localparam logic [CCD_W-1:0] CCD_LOAD = CCD_W'(T_CCD - 1);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  // Unpacked views of the per-bank command and address buses.
  logic [2:0]           cmd_arr  [NUM_BANKS];
  logic [ADDR_BITS-1:0] addr_arr [NUM_BANKS];

  logic [NUM_BANKS-1:0] req;
  logic [NUM_BANKS-1:0] elig;
  logic [NUM_BANKS-1:0] grant;
  logic                 grant_any;
  logic                 ref_found;
  logic [BANK_BITS-1:0] grant_idx;
  logic [BANK_BITS-1:0] rr_idx;
  logic [2:0]           grant_cmd;
  logic [ADDR_BITS-1:0] grant_addr;

  logic [BANK_BITS-1:0] rr_ptr;
  logic [RCD_W-1:0]     rcd_cnt [NUM_BANKS];
  logic [RP_W-1:0]      rp_cnt  [NUM_BANKS];
  logic [RRD_W-1:0]     rrd_cnt;
  logic [CCD_W-1:0]     ccd_cnt;

  // Decode each bank's command into a request and an eligibility flag.
  // A request is a real command (ACT..REF) with bank_issue set. NOP and the
  // illegal codes never request, so they can never be stalled.
  // Eligibility adds the timing gates:
  //   - ACT waits on its own bank's tRP and on the shared tRRD.
  //   - REF waits only on its own bank's tRP.
  //   - RD/WR wait on their own bank's tRCD and on the shared tCCD.
  //   - PRE is never held back here; ordering PRE correctly is the bank
  //     FSM's job.
  always_comb begin
    req  = '0;
    elig = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      cmd_arr[i]  = bank_cmd[3*i +: 3];
      addr_arr[i] = bank_addr[ADDR_BITS*i +: ADDR_BITS];
      req[i]      = bank_issue[i] && (cmd_arr[i] >= CMD_ACT) && (cmd_arr[i] <= CMD_REF);
      case (cmd_arr[i])
        CMD_ACT: elig[i] = req[i] && (rp_cnt[i] == '0) && (rrd_cnt == '0);
        CMD_REF: elig[i] = req[i] && (rp_cnt[i] == '0);
        CMD_RD,
        CMD_WR:  elig[i] = req[i] && (rcd_cnt[i] == '0) && (ccd_cnt == '0);
        CMD_PRE: elig[i] = req[i];
        default: elig[i] = 1'b0;
      endcase
    end
  end

  // Pick at most one winner.
  //   1. If any refresh is eligible, the lowest-index eligible refresh wins.
  //      Refresh deadlines are not negotiable.
  //   2. Otherwise, walk the banks starting at rr_ptr and take the first
  //      eligible one.
  // While rst is high nothing is granted. As a result, every requester sees
  // bank_stall during reset.
  always_comb begin
    grant_any = 1'b0;
    ref_found = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!ref_found && elig[i] && (cmd_arr[i] == CMD_REF)) begin
        ref_found = 1'b1;
        grant_idx = BANK_BITS'(i);
      end
    end
    if (ref_found) begin
      grant_any = 1'b1;
    end else begin
      // NUM_BANKS is a power of two, so the wrap is just truncation.
      for (int k = 0; k < NUM_BANKS; k++) begin
        rr_idx = rr_ptr + BANK_BITS'(k);
        if (!grant_any && elig[rr_idx]) begin
          grant_any = 1'b1;
          grant_idx = rr_idx;
        end
      end
    end
    if (rst) begin
      grant_any = 1'b0;
    end
  end

  // Expand the winner into a one-hot vector and fetch its command and
  // address. A bank is stalled exactly when it asked and did not win.
  always_comb begin
    grant = '0;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
    grant_cmd  = cmd_arr[grant_idx];
    grant_addr = addr_arr[grant_idx];
    bank_stall = req & ~grant;
  end

  // Bus register. The winner's command appears on the bus one cycle after
  // the grant.
  // On a cycle with no grant, only cmd_valid drops. The other fields keep
  // their last value so the bus does not toggle needlessly.
  // Reset discards any command that is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_type  <= CMD_NOP;
      cmd_bank  <= '0;
      cmd_addr  <= '0;
    end else if (grant_any) begin
      cmd_valid <= 1'b1;
      cmd_type  <= grant_cmd;
      cmd_bank  <= grant_idx;
      cmd_addr  <= grant_addr;
    end else begin
      cmd_valid <= 1'b0;
    end
  end

  // Round-robin pointer. After any grant, the bank just past the winner gets
  // first look next time. A refresh grant moves the pointer too.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= grant_idx + 1'b1;
    end
  end

  // Per-bank spacing counters.
  //   - A granted ACT arms tRCD on its own bank.
  //   - A granted PRE arms tRP on its own bank.
  // Otherwise each counter counts down to zero and stays there.
  // A load wins over the decrement in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        rcd_cnt[i] <= '0;
        rp_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (grant[i] && (cmd_arr[i] == CMD_ACT)) begin
          rcd_cnt[i] <= RCD_LOAD;
        end else if (rcd_cnt[i] != '0) begin
          rcd_cnt[i] <= rcd_cnt[i] - 1'b1;
        end
        if (grant[i] && (cmd_arr[i] == CMD_PRE)) begin
          rp_cnt[i] <= RP_LOAD;
        end else if (rp_cnt[i] != '0) begin
          rp_cnt[i] <= rp_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Bus-wide spacing counters.
  //   - tRRD separates any two ACTs, whichever banks issue them.
  //   - tCCD separates any two column commands (RD or WR), whichever banks
  //     issue them.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrd_cnt <= '0;
      ccd_cnt <= '0;
    end else begin
      if (grant_any && (grant_cmd == CMD_ACT)) begin
        rrd_cnt <= RRD_LOAD;
      end else if (rrd_cnt != '0) begin
        rrd_cnt <= rrd_cnt - 1'b1;
      end
      if (grant_any && ((grant_cmd == CMD_RD) || (grant_cmd == CMD_WR))) begin
        ccd_cnt <= CCD_LOAD;
      end else if (ccd_cnt != '0) begin
        ccd_cnt <= ccd_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bank_cmd_arbiter
//
// Directed bench for bank_cmd_arbiter with NUM_BANKS=4, T_RCD=3, T_RP=3,
// T_RRD=2 and T_CCD=2.
//
// Timing of stimulus and sampling:
//   - Inputs change 1 time unit after a rising edge.
//   - bank_stall and the registered bus outputs are sampled on the falling
//     edge.
//   - "Cycle c" is the window in which the inputs for cycle c are presented.
//   - A grant in cycle c appears on the bus in cycle c+1.
// ---------------------------------------------------------------------------
module tb_bank_cmd_arbiter;

  localparam logic [2:0] NOP = 3'd0;
  localparam logic [2:0] ACT = 3'd1;
  localparam logic [2:0] RD  = 3'd2;
  localparam logic [2:0] PRE = 3'd4;
  localparam logic [2:0] REF = 3'd5;
  localparam logic [2:0] ILL = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  bank_issue;
  logic [11:0] bank_cmd;
  logic [63:0] bank_addr;
  logic [3:0]  bank_stall;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_addr;

  int total = 0;
  int bad   = 0;

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  bank_cmd_arbiter #(
    .NUM_BANKS(4),
    .ADDR_BITS(16),
    .T_RCD(3),
    .T_RP(3),
    .T_RRD(2),
    .T_CCD(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bank_issue(bank_issue),
    .bank_cmd(bank_cmd),
    .bank_addr(bank_addr),
    .bank_stall(bank_stall),
    .cmd_valid(cmd_valid),
    .cmd_type(cmd_type),
    .cmd_bank(cmd_bank),
    .cmd_addr(cmd_addr)
  );

  // Safety net: stops the run if the sequence below ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before the sequence ended");
    $fatal(1, "[TB] watchdog expired");
  end

  // Move to just after the next rising edge, ready to drive new inputs.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Set bank b's issue bit, command code and address.
  task automatic drive_bank(input int b, input logic issue, input logic [2:0] cmd,
                            input logic [15:0] addr);
    bank_issue[b]        = issue;
    bank_cmd[3*b +: 3]   = cmd;
    bank_addr[16*b +: 16] = addr;
  endtask

  // Drop every bank's request.
  task automatic clear_all();
    bank_issue = '0;
    bank_cmd   = '0;
    bank_addr  = '0;
  endtask

  // Hold rst for one edge, then release it with all inputs idle.
  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    next_cycle();
    rst = 1'b0;
  endtask

  // During reset, nothing is granted, so every requester is stalled.
  // After reset, the bus registers read zero.
  task automatic test_reset();
    rst = 1'b1;
    clear_all();
    drive_bank(0, 1'b1, ACT, 16'h00AA);
    drive_bank(2, 1'b1, RD, 16'h00BB);
    drive_bank(3, 1'b1, NOP, 16'h00CC);
    next_cycle();
    @(negedge clk);
    total++; if (bank_stall !== 4'b0101) begin bad++; $display("[TB] FAIL reset_stall: got %b want %b", bank_stall, 4'b0101); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", cmd_valid); end
    total++; if (cmd_type !== 3'd0) begin bad++; $display("[TB] FAIL reset_type: got %0d want 0", cmd_type); end
    total++; if (cmd_bank !== 2'd0) begin bad++; $display("[TB] FAIL reset_bank: got %0d want 0", cmd_bank); end
    total++; if (cmd_addr !== 16'h0000) begin bad++; $display("[TB] FAIL reset_addr: got %h want 0000", cmd_addr); end
    next_cycle();
    rst = 1'b0;
    clear_all();
  endtask

  // Bank0 issues ACT, then holds RD.
  // RD is blocked for the two cycles after ACT (tRCD=3) and granted in the
  // third.
  task automatic test_act_then_rd();
    do_reset();
    drive_bank(0, 1'b1, ACT, 16'h1234);
    @(negedge clk);
    total++; if (bank_stall !== 4'b0000) begin bad++; $display("[TB] FAIL actrd_c0_stall: got %b want 0000", bank_stall); end
    next_cycle();
    drive_bank(0, 1'b1, RD, 16'h0040);
    @(negedge clk);
    total++; if (cmd_valid !== 1'b1 || cmd_type !== ACT || cmd_bank !== 2'd0 || cmd_addr !== 16'h1234) begin
      bad++; $display("[TB] FAIL actrd_c1_bus: got v=%b t=%0d b=%0d a=%h want v=1 t=1 b=0 a=1234", cmd_valid, cmd_type, cmd_bank, cmd_addr);
    end
    total++; if (bank_stall !== 4'b0001) begin bad++; $display("[TB] FAIL actrd_c1_stall: got %b want 0001", bank_stall); end
    next_cycle();
    @(negedge clk);
    total++; if (bank_stall !== 4'b0001) begin bad++; $display("[TB] FAIL actrd_c2_stall: got %b want 0001", bank_stall); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL actrd_c2_valid: got %b want 0", cmd_valid); end
    next_cycle();
    @(negedge clk);
    total++; if (bank_stall !== 4'b0000) begin bad++; $display("[TB] FAIL actrd_c3_stall: got %b want 0000", bank_stall); end
    next_cycle();
    drive_bank(0, 1'b0, NOP, 16'h0000);
    @(negedge clk);
    total++; if (cmd_valid !== 1'b1 || cmd_type !== RD || cmd_bank !== 2'd0 || cmd_addr !== 16'h0040) begin
      bad++; $display("[TB] FAIL actrd_c4_bus: got v=%b t=%0d b=%0d a=%h want v=1 t=2 b=0 a=0040", cmd_valid, cmd_type, cmd_bank, cmd_addr);
    end
    clear_all();
  endtask

  // All four banks issue ACT together.
  // tRRD=2 spaces the grants out to cycles 0, 2, 4 and 6, in bank order.
  // Each bank drops its request once it has been granted.
  task automatic test_all_act();
    logic [3:0] exp_stall [8];
    exp_stall = '{4'b1110, 4'b1110, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    do_reset();
    for (int b = 0; b < 4; b++) drive_bank(b, 1'b1, ACT, 16'(16'h0100 + b));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++; if (bank_stall !== exp_stall[c]) begin bad++; $display("[TB] FAIL allact_stall c=%0d: got %b want %b", c, bank_stall, exp_stall[c]); end
      if (c % 2 == 1) begin
        total++; if (cmd_valid !== 1'b1 || cmd_type !== ACT || cmd_bank !== 2'(c / 2) || cmd_addr !== 16'(16'h0100 + c / 2)) begin
          bad++; $display("[TB] FAIL allact_bus c=%0d: got v=%b t=%0d b=%0d a=%h want v=1 t=1 b=%0d", c, cmd_valid, cmd_type, cmd_bank, cmd_addr, c / 2);
        end
      end else begin
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL allact_idle c=%0d: got v=%b want 0", c, cmd_valid); end
      end
      next_cycle();
      if (c % 2 == 0) drive_bank(c / 2, 1'b0, NOP, 16'h0000);
    end
    clear_all();
  endtask

  // Banks 1 and 3 issue RD continuously.
  // tCCD=2 allows one grant every two cycles, and round-robin alternates the
  // winner: 1, 3, 1, 3.
  task automatic test_rd_alternate();
    logic [3:0] exp_stall [4];
    exp_stall = '{4'b1000, 4'b1010, 4'b0010, 4'b1010};
    do_reset();
    drive_bank(1, 1'b1, RD, 16'h0011);
    drive_bank(3, 1'b1, RD, 16'h0033);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++; if (bank_stall !== exp_stall[c % 4]) begin bad++; $display("[TB] FAIL rdalt_stall c=%0d: got %b want %b", c, bank_stall, exp_stall[c % 4]); end
      if (c % 2 == 1) begin
        total++; if (cmd_valid !== 1'b1 || cmd_type !== RD || cmd_bank !== (((c / 2) % 2 == 0) ? 2'd1 : 2'd3)) begin
          bad++; $display("[TB] FAIL rdalt_bus c=%0d: got v=%b t=%0d b=%0d want v=1 t=2 b=%0d", c, cmd_valid, cmd_type, cmd_bank, ((c / 2) % 2 == 0) ? 1 : 3);
        end
      end else begin
        total++; if (cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL rdalt_idle c=%0d: got v=%b want 0", c, cmd_valid); end
      end
      next_cycle();
    end
    clear_all();
  endtask

  // Refresh beats a round-robin RD.
  // Part A: the RD is granted on the following cycle.
  // Part B: a PRE from bank3 in that following cycle wins over bank0,
  // because the REF grant moved rr_ptr to 3.
  task automatic test_ref_priority();
    do_reset();
    drive_bank(0, 1'b1, RD, 16'h0500);
    drive_bank(2, 1'b1, REF, 16'h0000);
    @(negedge clk);
    total++; if (bank_stall !== 4'b0001) begin bad++; $display("[TB] FAIL ref_c0_stall: got %b want 0001", bank_stall); end
    next_cycle();
    drive_bank(2, 1'b0, NOP, 16'h0000);
    @(negedge clk);
    total++; if (bank_stall !== 4'b0000) begin bad++; $display("[TB] FAIL ref_c1_stall: got %b want 0000", bank_stall); end
    total++; if (cmd_valid !== 1'b1 || cmd_type !== REF || cmd_bank !== 2'd2) begin
      bad++; $display("[TB] FAIL ref_c1_bus: got v=%b t=%0d b=%0d want v=1 t=5 b=2", cmd_valid, cmd_type, cmd_bank);
    end
    next_cycle();
    drive_bank(0, 1'b0, NOP, 16'h0000);
    @(negedge clk);
    total++; if (cmd_valid !== 1'b1 || cmd_type !== RD || cmd_bank !== 2'd0 || cmd_addr !== 16'h0500) begin
      bad++; $display("[TB] FAIL ref_c2_bus: got v=%b t=%0d b=%0d a=%h want v=1 t=2 b=0 a=0500", cmd_valid, cmd_type, cmd_bank, cmd_addr);
    end
    clear_all();

    do_reset();
    drive_bank(0, 1'b1, RD, 16'h0500);
    drive_bank(2, 1'b1, REF, 16'h0000);
    @(negedge clk);
    total++; if (bank_stall !== 4'b0001) begin bad++; $display("[TB] FAIL refb_c0_stall: got %b want 0001", bank_stall); end
    next_cycle();
    drive_bank(2, 1'b0, NOP, 16'h0000);
    drive_bank(3, 1'b1, PRE, 16'h0300);
    @(negedge clk);
    total++; if (bank_stall !== 4'b0001) begin bad++; $display("[TB] FAIL refb_rrptr_stall: got %b want 0001", bank_stall); end
    next_cycle();
    drive_bank(3, 1'b0, NOP, 16'h0000);
    @(negedge clk);
    total++; if (bank_stall !== 4'b0000) begin bad++; $display("[TB] FAIL refb_c2_stall: got %b want 0000", bank_stall); end
    total++; if (cmd_valid !== 1'b1 || cmd_type !== PRE || cmd_bank !== 2'd3) begin
      bad++; $display("[TB] FAIL refb_c2_bus: got v=%b t=%0d b=%0d want v=1 t=4 b=3", cmd_valid, cmd_type, cmd_bank);
    end
    clear_all();
  endtask

  // Bank1 PRE, then ACT.
  // The ACT is blocked for two cycles (tRP=3) and granted in the third.
  // After that, an illegal code and a NOP with bank_issue set must be
  // neither granted nor stalled.
  task automatic test_pre_act();
    do_reset();
    drive_bank(1, 1'b1, PRE, 16'h0000);
    @(negedge clk);
    total++; if (bank_stall !== 4'b0000) begin bad++; $display("[TB] FAIL preact_c0_stall: got %b want 0000", bank_stall); end
    next_cycle();
    drive_bank(1, 1'b1, ACT, 16'h0777);
    @(negedge clk);
    total++; if (bank_stall !== 4'b0010) begin bad++; $display("[TB] FAIL preact_c1_stall: got %b want 0010", bank_stall); end
    total++; if (cmd_valid !== 1'b1 || cmd_type !== PRE || cmd_bank !== 2'd1) begin
      bad++; $display("[TB] FAIL preact_c1_bus: got v=%b t=%0d b=%0d want v=1 t=4 b=1", cmd_valid, cmd_type, cmd_bank);
    end
    next_cycle();
    @(negedge clk);
    total++; if (bank_stall !== 4'b0010) begin bad++; $display("[TB] FAIL preact_c2_stall: got %b want 0010", bank_stall); end
    next_cycle();
    @(negedge clk);
    total++; if (bank_stall !== 4'b0000) begin bad++; $display("[TB] FAIL preact_c3_stall: got %b want 0000", bank_stall); end
    next_cycle();
    drive_bank(1, 1'b1, ILL, 16'hFFFF);
    @(negedge clk);
    total++; if (cmd_valid !== 1'b1 || cmd_type !== ACT || cmd_bank !== 2'd1 || cmd_addr !== 16'h0777) begin
      bad++; $display("[TB] FAIL preact_c4_bus: got v=%b t=%0d b=%0d a=%h want v=1 t=1 b=1 a=0777", cmd_valid, cmd_type, cmd_bank, cmd_addr);
    end
    total++; if (bank_stall !== 4'b0000) begin bad++; $display("[TB] FAIL illegal_stall: got %b want 0000", bank_stall); end
    next_cycle();
    drive_bank(1, 1'b1, NOP, 16'h0000);
    @(negedge clk);
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL illegal_nogrant: got v=%b want 0", cmd_valid); end
    total++; if (bank_stall !== 4'b0000) begin bad++; $display("[TB] FAIL nop_stall: got %b want 0000", bank_stall); end
    next_cycle();
    @(negedge clk);
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL nop_nogrant: got v=%b want 0", cmd_valid); end
    clear_all();
  endtask

  // Reset arrives while an ACT is on the bus and tRCD is still running.
  // Expected after reset:
  //   - The in-flight ACT is dropped.
  //   - Bank0's RD goes out on the first cycle after reset.
  //   - rr_ptr is back at 0, so bank0 beats a competing RD from bank1.
  task automatic test_reset_mid();
    do_reset();
    drive_bank(0, 1'b1, ACT, 16'h0ABC);
    next_cycle();
    rst = 1'b1;
    drive_bank(0, 1'b1, RD, 16'h00C0);
    @(negedge clk);
    total++; if (cmd_valid !== 1'b1 || cmd_type !== ACT) begin bad++; $display("[TB] FAIL rstmid_inflight: got v=%b t=%0d want v=1 t=1", cmd_valid, cmd_type); end
    total++; if (bank_stall !== 4'b0001) begin bad++; $display("[TB] FAIL rstmid_stall: got %b want 0001", bank_stall); end
    next_cycle();
    rst = 1'b0;
    drive_bank(1, 1'b1, RD, 16'h00C1);
    @(negedge clk);
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_discard: got v=%b want 0", cmd_valid); end
    total++; if (bank_stall !== 4'b0010) begin bad++; $display("[TB] FAIL rstmid_grant: got %b want 0010", bank_stall); end
    next_cycle();
    clear_all();
    @(negedge clk);
    total++; if (cmd_valid !== 1'b1 || cmd_type !== RD || cmd_bank !== 2'd0 || cmd_addr !== 16'h00C0) begin
      bad++; $display("[TB] FAIL rstmid_bus: got v=%b t=%0d b=%0d a=%h want v=1 t=2 b=0 a=00C0", cmd_valid, cmd_type, cmd_bank, cmd_addr);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    test_reset();
    test_act_then_rd();
    test_all_act();
    test_rd_alternate();
    test_ref_priority();
    test_pre_act();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
